// File: rtl/sync_filter.sv
// Multi-channel input conditioner: per-channel flop-chain synchroniser followed by a
// stability-counter debounce. Define SYNC_FILTER_EDGE_EN to enable the rise_o/fall_o pulses.
module sync_filter #(
  parameter int                  CHANNELS      = 8,
  parameter int                  SYNC_REGS     = 3,
  parameter int                  FILTER_CYCLES = 16,
  parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [CHANNELS-1:0] data_i,
  output logic [CHANNELS-1:0] data_o,
  output logic                changed_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o
);

  localparam int              CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

  // Stage 0 samples the raw inputs; stage SYNC_REGS-1 feeds the filter.
  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [SYNC_REGS-1:0][CHANNELS-1:0] sync_r;

  logic [CHANNELS-1:0] sync_s;
  logic [CNT_W-1:0]    cnt_r   [CHANNELS];
  logic [CNT_W-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] data_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_r <= {SYNC_REGS{RESET_VAL}};
    else       sync_r <= {sync_r[SYNC_REGS-2:0], data_i};
  end

  assign sync_s = sync_r[SYNC_REGS-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    data_nxt = data_o;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_nxt[c] = '0;
      if (sync_s[c] != data_o[c]) begin
        if (cnt_r[c] == CNT_MAX) data_nxt[c] = sync_s[c];
        else                     cnt_nxt[c] = cnt_r[c] + CNT_W'(1);
      end
    end
  end

  // NOTE: the counter array is reset explicitly; it is per-channel control state, not RAM,
  // and a mid-filter reset must restart every debounce window from zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < CHANNELS; c++) cnt_r[c] <= '0;
      data_o    <= RESET_VAL;
      changed_o <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) cnt_r[c] <= cnt_nxt[c];
      data_o    <= data_nxt;
      changed_o <= |(data_nxt ^ data_o);
    end
  end

`ifdef SYNC_FILTER_EDGE_EN
  // Edge pulses are registered alongside data_o so they coincide with the level change.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_o <= '0;
      fall_o <= '0;
    end else begin
      rise_o <= data_nxt & ~data_o;
      fall_o <= ~data_nxt & data_o;
    end
  end
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed self-checking bench for sync_filter (4 channels, 3 sync stages, 4-cycle filter,
// reset level 4'b0101). Edge-pulse expectations follow SYNC_FILTER_EDGE_EN.
module tb_sync_filter;

`ifdef SYNC_FILTER_EDGE_EN
  localparam logic [3:0] EDGE_MASK = 4'hF;
`else
  localparam logic [3:0] EDGE_MASK = 4'h0;
`endif

  logic       clk_i;
  logic       rst_i;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       changed_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;

  int n_cmp = 0;
  int n_err = 0;

  sync_filter #(
    .CHANNELS      (4),
    .SYNC_REGS     (3),
    .FILTER_CYCLES (4),
    .RESET_VAL     (4'b0101)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .changed_o (changed_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] d, input logic ch,
                           input logic [3:0] r, input logic [3:0] f);
    check({tag, ".data"},    32'(data_o),    32'(d));
    check({tag, ".changed"}, 32'(changed_o), 32'(ch));
    check({tag, ".rise"},    32'(rise_o),    32'(r & EDGE_MASK));
    check({tag, ".fall"},    32'(fall_o),    32'(f & EDGE_MASK));
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic cyc(input string tag, input logic [3:0] d, input logic ch,
                     input logic [3:0] r, input logic [3:0] f);
    @(posedge clk_i);
    #1;
    check_all(tag, d, ch, r, f);
  endtask

  task automatic quiet(input string tag, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(tag, d, 1'b0, 4'b0, 4'b0);
  endtask

  initial begin
    rst_i  = 1'b0;
    data_i = 4'b0101;
    #2 rst_i = 1'b1;
    #2;
    check_all("reset", 4'b0101, 1'b0, 4'b0, 4'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Idle at reset level: nothing moves.
    quiet("idle", 4'b0101, 20);

    // Channel 1 rises: accepted on the 7th edge.
    data_i = 4'b0111;
    quiet("ch1_rise_wait", 4'b0101, 6);
    cyc("ch1_rise", 4'b0111, 1'b1, 4'b0010, 4'b0000);
    quiet("ch1_rise_hold", 4'b0111, 2);

    // Channel 1 back low.
    data_i = 4'b0101;
    quiet("ch1_fall_wait", 4'b0111, 6);
    cyc("ch1_fall", 4'b0101, 1'b1, 4'b0000, 4'b0010);
    quiet("ch1_fall_hold", 4'b0101, 2);

    // 3-cycle glitch on channel 3 is rejected.
    data_i = 4'b1101;
    quiet("glitch3_hi", 4'b0101, 3);
    data_i = 4'b0101;
    quiet("glitch3_lo", 4'b0101, 12);

    // 4-cycle pulse on channel 3 is accepted and lasts 4 cycles.
    data_i = 4'b1101;
    quiet("pulse4_hi", 4'b0101, 4);
    data_i = 4'b0101;
    quiet("pulse4_wait", 4'b0101, 2);
    cyc("pulse4_rise", 4'b1101, 1'b1, 4'b1000, 4'b0000);
    quiet("pulse4_hold", 4'b1101, 3);
    cyc("pulse4_fall", 4'b0101, 1'b1, 4'b0000, 4'b1000);
    quiet("pulse4_after", 4'b0101, 3);

    // All channels flip together: one update, one strobe.
    data_i = 4'b1010;
    quiet("flip_wait", 4'b0101, 6);
    cyc("flip", 4'b1010, 1'b1, 4'b1010, 4'b0101);
    quiet("flip_hold", 4'b1010, 2);

    data_i = 4'b0101;
    quiet("unflip_wait", 4'b1010, 6);
    cyc("unflip", 4'b0101, 1'b1, 4'b0101, 4'b1010);
    quiet("unflip_hold", 4'b0101, 2);

    // Channel 0 falls, reset hits mid-filter.
    data_i = 4'b0100;
    quiet("midrst_pre", 4'b0101, 5);
    rst_i = 1'b1;
    #1;
    check_all("midrst_async", 4'b0101, 1'b0, 4'b0, 4'b0);
    quiet("midrst_held", 4'b0101, 2);
    rst_i = 1'b0;
    quiet("midrst_refilter", 4'b0101, 6);
    cyc("midrst_fall", 4'b0100, 1'b1, 4'b0000, 4'b0001);
    quiet("midrst_after", 4'b0100, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
